// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM states and reset PC.
package pc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/jump_target.sv
// J-type jump target: upper nibble of the current PC, the 26-bit field, word aligned.
module jump_target (
  input  logic [31:0] pc,
  input  logic [25:0] jump_addr,
  output logic [31:0] target
);

  // Only the region nibble of pc participates in the target.
  logic w_unused;
  assign w_unused = ^pc[27:0];

  assign target = {pc[31:28], jump_addr, 2'b00};

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (jr > jump > taken branch > pc+4),
// RUN/HALT control with misaligned-jr fault, and a retired-advance counter.
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        is_jump,
  input  logic        is_jr,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [25:0] jump_addr,
  input  logic [15:0] branch_imm,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  pc_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_fault;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_branch_off;
  logic [31:0] w_next_pc;
  logic        w_jr_misaligned;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_off    = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign w_jr_misaligned = is_jr && (jr_target[1:0] != 2'b00);

  jump_target u_jump_target (
    .pc        (r_pc),
    .jump_addr (jump_addr),
    .target    (w_jump_tgt)
  );

  // Next-PC mux in fixed priority order; lower-priority requests are ignored.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (is_jr) begin
      w_next_pc = jr_target;
    end else if (is_jump) begin
      w_next_pc = w_jump_tgt;
    end else if (is_branch && branch_taken) begin
      w_next_pc = w_pc_plus4 + w_branch_off;
    end
  end

  // RUN/HALT FSM with PC, retired counter and one-cycle fault pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (en) begin
            if (w_jr_misaligned) begin
              r_state <= ST_HALT;
              r_fault <= 1'b1;
            end else begin
              r_pc      <= w_next_pc;
              r_retired <= r_retired + 32'd1;
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign halted   = (r_state == ST_HALT);
  assign fault    = r_fault;
  assign retired  = r_retired;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus randomized traffic
// against a behavioural PC model.
module tb_pc_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        is_jump;
  logic        is_jr;
  logic        is_branch;
  logic        branch_taken;
  logic [25:0] jump_addr;
  logic [15:0] branch_imm;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  always #5 clk = ~clk;

  pc_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .is_jump      (is_jump),
    .is_jr        (is_jr),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .jump_addr    (jump_addr),
    .branch_imm   (branch_imm),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    logic        halt;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [31:0] m_pc   = '0;
  logic [31:0] m_ret  = '0;
  bit          m_halt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge state.
  task automatic step(input bit rst, input bit e, input bit jr, input bit j,
                      input bit br, input bit tk, input logic [25:0] ja,
                      input logic [15:0] bi, input logic [31:0] jt);
    exp_t x;
    bit   f;
    int   off;
    @(negedge clk);
    reset = rst; en = e; is_jr = jr; is_jump = j; is_branch = br;
    branch_taken = tk; jump_addr = ja; branch_imm = bi; jr_target = jt;
    f = 1'b0;
    if (rst) begin
      m_pc = TB_RESET_PC; m_ret = 0; m_halt = 1'b0;
    end else if (!m_halt && e) begin
      if (jr) begin
        if (jt % 4 != 0) begin
          m_halt = 1'b1;
          f      = 1'b1;
        end else begin
          m_pc  = jt;
          m_ret = m_ret + 1;
        end
      end else begin
        if (j) begin
          m_pc = (m_pc & 32'hF000_0000) + 32'(ja) * 4;
        end else if (br && tk) begin
          off  = $signed(bi);
          m_pc = m_pc + 4 + 32'(off * 4);
        end else begin
          m_pc = m_pc + 4;
        end
        m_ret = m_ret + 1;
      end
    end
    x.pc = m_pc; x.ret = m_ret; x.halt = m_halt; x.fault = f;
    q.push_back(x);
  endtask

  task automatic seq(input bit e);
    step(1'b0, e, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic jr_to(input logic [31:0] t);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, t);
  endtask

  // Monitor: compare DUT outputs to the oldest expectation after each edge.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("pc",       pc,             x.pc);
      chk("pc_plus4", pc_plus4,       x.pc + 32'd4);
      chk("retired",  retired,        x.ret);
      chk("halted",   {31'd0, halted}, {31'd0, x.halt});
      chk("fault",    {31'd0, fault},  {31'd0, x.fault});
    end
  end

  initial begin
    bit          r_e, r_jr, r_j, r_br, r_tk, r_rst;
    logic [31:0] r_jt;
    reset = 1'b1; en = 1'b0; is_jump = 1'b0; is_jr = 1'b0; is_branch = 1'b0;
    branch_taken = 1'b0; jump_addr = '0; branch_imm = '0; jr_target = '0;

    // Reset held for two cycles, with requests asserted that must be ignored
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 26'h3FF_FFFF, '0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 32'h42);

    // Sequential: 4, 8, 12 with retired=3
    seq(1'b1); seq(1'b1); seq(1'b1);

    // Jump keeps the region nibble of the current pc
    jr_to(32'hC000_0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 26'h2AA_AAAA, '0, '0);

    // Backward branch by one word lands back on itself; not-taken falls through
    jr_to(32'h0000_0100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0, 16'hFFFF, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 16'hFFFF, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0, 16'h0010, '0);

    // Priority: jr wins over jump and taken branch
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 26'h123_4567, 16'h0008, 32'h40);

    // Wrap at top of address space, then stall with a jump request
    jr_to(32'hFFFF_FFFC);
    seq(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 26'h155_5555, '0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 32'h43);

    // Misaligned jr: fault pulse, halt, frozen state, then reset recovery
    jr_to(32'h42);
    seq(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 26'h000_0010, '0, '0);
    jr_to(32'h80);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    seq(1'b1);

    // Reset coincident with a faulting jr wins
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 32'h1);
    seq(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_e   = ($urandom_range(0, 3) != 0);
      r_jr  = ($urandom_range(0, 5) == 0);
      r_j   = ($urandom_range(0, 4) == 0);
      r_br  = ($urandom_range(0, 2) == 0);
      r_tk  = $urandom_range(0, 1) == 1;
      r_jt  = $urandom;
      if ($urandom_range(0, 15) != 0) r_jt[1:0] = 2'b00;
      step(r_rst, r_e, r_jr, r_j, r_br, r_tk, 26'($urandom), 16'($urandom), r_jt);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
